// File: rtl/fetch_unit_pkg.sv
// Purpose : shared definitions for the fetch stage (FSM states, NOP encoding,
//           default exception vector, instruction field positions).
// Latency : n/a (definitions only).  Backpressure: n/a.
package fetch_unit_pkg;

    // FSM state encoding, kept as plain constants for legacy tools.
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t ST_RUN = 1'b0;
    localparam fetch_state_t ST_EXC = 1'b1;

    // A bubble in IF/ID is encoded as this instruction word.
    localparam logic [15:0] NOP_INSTR          = 16'h0000;
    localparam logic [15:0] DEFAULT_EXC_VECTOR = 16'h0040;

    // Instruction field positions.
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int OP1_MSB    = 11;
    localparam int OP1_LSB    = 8;
    localparam int OP2_MSB    = 7;
    localparam int OP2_LSB    = 4;
    localparam int FUNCT_MSB  = 3;
    localparam int FUNCT_LSB  = 0;

    function automatic logic [3:0] get_opcode(input logic [15:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// Purpose : IF/ID pipeline register with load / bubble / hold controls.
// Latency : 1 cycle from load to outputs.
// Backpressure: holds contents when neither load nor bubble is asserted.
// Ports   : clk, rst (async active-low), load, bubble, instr_in, pc2_in ->
//           instr, pc2, valid.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc2_in,
    output logic [15:0] instr,
    output logic [15:0] pc2,
    output logic        valid
);

    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;

    // Bubble wins over load; a bubble leaves pc2 untouched.
    always_comb begin
        instr_d = instr_q;
        pc2_d   = pc2_q;
        valid_d = valid_q;
        if (bubble) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc2_d   = pc2_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= NOP_INSTR;
            pc2_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc2   = pc2_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Purpose : instruction fetch stage: PC, redirect/exception FSM, IF/ID register.
// Latency : 1 cycle (word at imem_addr appears on ifid_instr after the next edge).
// Backpressure: stall holds PC and IF/ID; flush bubbles IF/ID even under stall.
// Ports   : clk, rst (async active-low), stall, flush, branch_taken,
//           branch_target, exception, imem_data -> imem_addr, ifid_instr,
//           ifid_pc2, ifid_valid, epc, align_fault.
// Config  : define FETCH_ALIGN_CHECK_EN to trap odd branch targets; otherwise
//           bit 0 of the target is dropped and align_fault stays low.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        exception,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc2,
    output logic        ifid_valid,
    output logic [15:0] epc,
    output logic        align_fault
);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  epc_q, epc_d;
    logic         align_fault_q, align_fault_d;

    logic         ifid_load, ifid_bubble;
    logic [15:0]  pc_plus2;
    logic [15:0]  tgt;
    logic         misaligned;

    assign pc_plus2 = pc_q + 16'd2;

`ifdef FETCH_ALIGN_CHECK_EN
    assign tgt        = branch_target;
    assign misaligned = branch_target[0];
`else
    assign tgt        = {branch_target[15:1], 1'b0};
    assign misaligned = 1'b0;
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = branch_target[0];
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        epc_d         = epc_q;
        align_fault_d = 1'b0;
        ifid_load     = 1'b0;
        ifid_bubble   = 1'b0;

        if (state_q == ST_RUN && exception && ifid_valid) begin
            // Instruction in IF/ID is bad: record its own address.
            epc_d       = ifid_pc2 - 16'd2;
            pc_d        = EXC_VECTOR;
            ifid_bubble = 1'b1;
            state_d     = ST_EXC;
        end else if (state_q == ST_RUN && branch_taken && misaligned) begin
            align_fault_d = 1'b1;
            epc_d         = branch_target;
            pc_d          = EXC_VECTOR;
            ifid_bubble   = 1'b1;
            state_d       = ST_EXC;
        end else if (state_q == ST_RUN && branch_taken) begin
            pc_d        = tgt;
            ifid_bubble = 1'b1;
        end else begin
            // Normal fetch; EXC lands here too since it ignores redirects.
            if (!stall) begin
                pc_d      = pc_plus2;
                ifid_load = 1'b1;
            end
            ifid_bubble = flush;
            state_d     = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            epc_q         <= 16'h0000;
            align_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            align_fault_q <= align_fault_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .instr_in (imem_data),
        .pc2_in   (pc_plus2),
        .instr    (ifid_instr),
        .pc2      (ifid_pc2),
        .valid    (ifid_valid)
    );

    assign imem_addr   = pc_q;
    assign epc         = epc_q;
    assign align_fault = align_fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose : directed self-checking bench for fetch_unit.
// Latency : n/a.  Backpressure: n/a.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, branch_taken, exception;
    logic [15:0] branch_target;
    logic [15:0] imem_addr, imem_data;
    logic [15:0] ifid_instr, ifid_pc2, epc;
    logic        ifid_valid, align_fault;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instruction memory: two fixed words, everything else 16'h2000 | addr.
    always_comb begin
        case (imem_addr)
            16'h0000: imem_data = 16'h1120;
            16'h001E: imem_data = 16'h1110;
            default:  imem_data = 16'h2000 | imem_addr;
        endcase
    end

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .exception     (exception),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ifid_instr    (ifid_instr),
        .ifid_pc2      (ifid_pc2),
        .ifid_valid    (ifid_valid),
        .epc           (epc),
        .align_fault   (align_fault)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] ins,
                            input logic [15:0] pc2, input logic vld);
        chk({tag, "_instr"}, ifid_instr, ins);
        chk({tag, "_pc2"}, ifid_pc2, pc2);
        chk({tag, "_valid"}, {15'd0, ifid_valid}, {15'd0, vld});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"}, imem_addr, 16'h0000);
        chk_ifid(tag, 16'h0000, 16'h0000, 1'b0);
        chk({tag, "_epc"}, epc, 16'h0000);
        chk({tag, "_align"}, {15'd0, align_fault}, 16'h0000);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        exception = 1'b0; branch_target = 16'h0000;
        #3;
        chk_reset("reset");

        // Release reset and fetch sequentially.
        step(); rst = 1'b1;
        chk("rel_addr0", imem_addr, 16'h0000);
        step();
        chk_ifid("fetch0", 16'h1120, 16'h0002, 1'b1);
        chk("fetch0_addr", imem_addr, 16'h0002);
        step();
        chk("fetch1_addr", imem_addr, 16'h0004);
        chk_ifid("fetch1", 16'h2002, 16'h0004, 1'b1);
        step();
        chk("fetch2_addr", imem_addr, 16'h0006);

        // Stall for two cycles at 0006.
        stall = 1'b1;
        step();
        chk("stall1_addr", imem_addr, 16'h0006);
        chk_ifid("stall1", 16'h2004, 16'h0006, 1'b1);
        step();
        chk("stall2_addr", imem_addr, 16'h0006);
        chk_ifid("stall2", 16'h2004, 16'h0006, 1'b1);
        stall = 1'b0;
        step();
        chk("resume_addr", imem_addr, 16'h0008);
        chk_ifid("resume", 16'h2006, 16'h0008, 1'b1);

        // Flush overrides stall for IF/ID only.
        stall = 1'b1; flush = 1'b1;
        step();
        chk("flstall_addr", imem_addr, 16'h0008);
        chk_ifid("flstall", 16'h0000, 16'h0008, 1'b0);
        stall = 1'b0; flush = 1'b0;
        step();
        chk("afterfl_addr", imem_addr, 16'h000A);
        chk_ifid("afterfl", 16'h2008, 16'h000A, 1'b1);

        // Flush alone: PC advances, bubble; then exception on a bubble is ignored.
        flush = 1'b1;
        step();
        chk("flush_addr", imem_addr, 16'h000C);
        chk_ifid("flush", 16'h0000, 16'h000A, 1'b0);
        flush = 1'b0; exception = 1'b1;
        step();
        exception = 1'b0;
        chk("excbub_addr", imem_addr, 16'h000E);
        chk_ifid("excbub", 16'h200C, 16'h000E, 1'b1);
        chk("excbub_epc", epc, 16'h0000);

        // Branch under stall.
        branch_taken = 1'b1; branch_target = 16'h001E; stall = 1'b1;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        chk("br_addr", imem_addr, 16'h001E);
        chk_ifid("br", 16'h0000, 16'h000E, 1'b0);
        step();
        chk_ifid("brtgt", 16'h1110, 16'h0020, 1'b1);
        chk("brtgt_addr", imem_addr, 16'h0020);

        // Put the word at 0x30 into IF/ID, then raise an exception on it.
        branch_taken = 1'b1; branch_target = 16'h0030;
        step();
        branch_taken = 1'b0;
        step();
        chk("pre_exc_pc2", ifid_pc2, 16'h0032);
        exception = 1'b1;
        step();
        chk("exc_epc", epc, 16'h0030);
        chk("exc_addr", imem_addr, 16'h0040);
        chk("exc_valid", {15'd0, ifid_valid}, 16'h0000);
        // In EXC: a second exception and a branch are both ignored.
        branch_taken = 1'b1; branch_target = 16'h0100;
        step();
        exception = 1'b0; branch_taken = 1'b0;
        chk("inexc_addr", imem_addr, 16'h0042);
        chk_ifid("inexc", 16'h2040, 16'h0042, 1'b1);
        chk("inexc_epc", epc, 16'h0030);
        step();
        chk("postexc_addr", imem_addr, 16'h0044);
        chk("postexc_epc", epc, 16'h0030);

        // PC wraparound at FFFE.
        branch_taken = 1'b1; branch_target = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        chk("wrap_pre_addr", imem_addr, 16'hFFFE);
        step();
        chk("wrap_addr", imem_addr, 16'h0000);
        chk_ifid("wrap", 16'hFFFE, 16'h0000, 1'b1);

        // Odd branch target.
        branch_taken = 1'b1; branch_target = 16'h0015;
        step();
        branch_taken = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_align", {15'd0, align_fault}, 16'h0001);
        chk("mis_epc", epc, 16'h0015);
        chk("mis_addr", imem_addr, 16'h0040);
        chk("mis_valid", {15'd0, ifid_valid}, 16'h0000);
        step();
        chk("mis2_align", {15'd0, align_fault}, 16'h0000);
        chk("mis2_addr", imem_addr, 16'h0042);
`else
        chk("mis_align", {15'd0, align_fault}, 16'h0000);
        chk("mis_epc", epc, 16'h0030);
        chk("mis_addr", imem_addr, 16'h0014);
        step();
        chk("mis2_addr", imem_addr, 16'h0016);
        chk_ifid("mis2", 16'h2014, 16'h0016, 1'b1);
`endif

        // Enter EXC, then reset asynchronously mid-cycle with stall high.
        exception = 1'b1;
        step();
        exception = 1'b0; stall = 1'b1;
        chk("rexc_addr", imem_addr, 16'h0040);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("arst");
        step();
        chk_reset("arst_hold");
        stall = 1'b0; rst = 1'b1;
        step();
        chk_ifid("postrst", 16'h1120, 16'h0002, 1'b1);
        chk("postrst_addr", imem_addr, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
